// File: rtl/zbus_arbiter.sv
// Round-robin arbiter: N zbus initiators share one zbus target, grant held until vld&ack.
// Optional ZBUS_ARB_LOCK_EN adds s_lck so an initiator can keep the grant across transfers.
module zbus_arbiter #(
  parameter int   N  = 2,
  parameter int   BW = 8,
  parameter logic XZ = 1'bx
) (
  input  logic            z_clk,
  input  logic            z_rst_n,
  input  logic [N-1:0]    s_vld,
  input  logic [N*BW-1:0] s_bus,
  output logic [N-1:0]    s_ack,
  output logic            m_vld,
  output logic [BW-1:0]   m_bus,
  input  logic            m_ack,
`ifdef ZBUS_ARB_LOCK_EN
  input  logic [N-1:0]    s_lck,
`endif
  output logic [N-1:0]    gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [PW-1:0] g_idx;
  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_g;
  logic [PW-1:0] idle_pick;
  logic [PW-1:0] busy_pick;
  logic [N-1:0]  busy_req;
  logic          xfer_done;
  logic          lock_hold;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == LAST) ? '0 : i + ONE;
  endfunction

  // First set bit of req, scanning upward from start with wrap-around.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] start);
    logic [PW-1:0] idx;
    logic [PW-1:0] pick;
    logic          found;
    idx   = start;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign nxt_g     = next_idx(g_idx);
  assign idle_pick = rr_pick(s_vld, ptr);
  assign busy_req  = s_vld & ~gnt;
  assign busy_pick = rr_pick(busy_req, nxt_g);
  assign xfer_done = (state == BUSY) && m_vld && m_ack;

`ifdef ZBUS_ARB_LOCK_EN
  assign lock_hold = s_lck[g_idx];
`else
  assign lock_hold = 1'b0;
`endif

  // Grant state: arbitration on request in IDLE, hand-over without idle cycle on completion.
  always_ff @(posedge z_clk or negedge z_rst_n) begin
    if (!z_rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      g_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_vld) begin
            state <= BUSY;
            g_idx <= idle_pick;
            gnt   <= onehot(idle_pick);
          end
        end
        BUSY: begin
          if (xfer_done && !lock_hold) begin
            ptr <= nxt_g;
            if (|busy_req) begin
              g_idx <= busy_pick;
              gnt   <= onehot(busy_pick);
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath mux toward the target and ack steering back to the granted initiator.
  always_comb begin
    m_vld = 1'b0;
    m_bus = {BW{XZ}};
    s_ack = '0;
    if (state == BUSY) begin
      for (int i = 0; i < N; i++) begin
        if (g_idx == PW'(i)) begin
          m_vld    = s_vld[i];
          m_bus    = s_bus[i*BW +: BW];
          s_ack[i] = m_ack;
        end
      end
    end
  end

endmodule

// File: tb/tb_zbus_arbiter.sv
// Self-checking bench for zbus_arbiter (N=4, BW=8, idle fill all-ones) against a behavioural model.
module tb_zbus_arbiter;
  localparam int N  = 4;
  localparam int BW = 8;

  logic            z_clk = 1'b0;
  logic            z_rst_n;
  logic [N-1:0]    s_vld;
  logic [N*BW-1:0] s_bus;
  logic [N-1:0]    s_ack;
  logic            m_vld;
  logic [BW-1:0]   m_bus;
  logic            m_ack;
  logic [N-1:0]    gnt;
  logic [N-1:0]    s_lck;

  int n_chk  = 0;
  int n_fail = 0;
  int mg;
  int mp;
  logic [N-1:0] done;

  zbus_arbiter #(.N(N), .BW(BW), .XZ(1'b1)) dut (
    .z_clk  (z_clk),
    .z_rst_n(z_rst_n),
    .s_vld  (s_vld),
    .s_bus  (s_bus),
    .s_ack  (s_ack),
    .m_vld  (m_vld),
    .m_bus  (m_bus),
    .m_ack  (m_ack),
`ifdef ZBUS_ARB_LOCK_EN
    .s_lck  (s_lck),
`endif
    .gnt    (gnt)
  );

  always #5 z_clk = ~z_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] e_gnt();
    return (mg < 0) ? 32'd0 : (32'd1 << mg);
  endfunction
  function automatic logic [31:0] e_vld();
    return (mg < 0) ? 32'd0 : 32'(s_vld[mg]);
  endfunction
  function automatic logic [31:0] e_bus();
    return (mg < 0) ? 32'hFF : 32'(s_bus[mg*BW +: BW]);
  endfunction
  function automatic logic [31:0] e_ack();
    return (mg < 0) ? 32'd0 : (32'(m_ack) << mg);
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the rising edge.
  task automatic tick();
    int  ng;
    int  np;
    bit  lk;
    @(negedge z_clk);
    chk("gnt",   32'(gnt),   e_gnt());
    chk("m_vld", 32'(m_vld), e_vld());
    chk("m_bus", 32'(m_bus), e_bus());
    chk("s_ack", 32'(s_ack), e_ack());
    ng   = mg;
    np   = mp;
    done = '0;
    if (mg < 0) begin
      for (int k = 0; k < N; k++)
        if (ng < 0 && s_vld[(mp + k) % N]) ng = (mp + k) % N;
    end else if (s_vld[mg] && m_ack) begin
      done[mg] = 1'b1;
      lk = 1'b0;
`ifdef ZBUS_ARB_LOCK_EN
      lk = s_lck[mg];
`endif
      if (!lk) begin
        np = (mg + 1) % N;
        ng = -1;
        for (int k = 1; k < N; k++)
          if (ng < 0 && s_vld[(mg + k) % N]) ng = (mg + k) % N;
      end
    end
    @(posedge z_clk);
    #1;
    mg = ng;
    mp = np;
  endtask

  // Initiators obey zbus: a pending request is held until its completion edge.
  task automatic drive(input logic [N-1:0] want);
    for (int i = 0; i < N; i++) begin
      if (done[i] || !s_vld[i]) begin
        s_vld[i]           = want[i];
        s_bus[i*BW +: BW]  = 8'($urandom);
      end
    end
  endtask

  task automatic rst_pulse(input int dly);
    #(dly);
    z_rst_n = 1'b0;
    #1;
    chk("rst_gnt",   32'(gnt),   32'd0);
    chk("rst_m_vld", 32'(m_vld), 32'd0);
    chk("rst_m_bus", 32'(m_bus), 32'hFF);
    chk("rst_s_ack", 32'(s_ack), 32'd0);
    s_vld = '0;
    m_ack = 1'b0;
    done  = '0;
    mg    = -1;
    mp    = 0;
    @(posedge z_clk);
    #1;
    z_rst_n = 1'b1;
  endtask

  task automatic drain();
    s_lck = '0;
    m_ack = 1'b1;
    repeat (6) begin
      tick();
      drive('0);
    end
    m_ack = 1'b0;
  endtask

  initial begin
    s_vld   = '0;
    s_bus   = '0;
    m_ack   = 1'b0;
    s_lck   = '0;
    done    = '0;
    mg      = -1;
    mp      = 0;
    z_rst_n = 1'b1;
    rst_pulse(2);

    // Arbitration latency from a single request
    drive(4'b0010);
    tick();
    chk("lat_gnt",   32'(gnt),   32'b0010);
    chk("lat_m_vld", 32'(m_vld), 32'd1);
    drain();

    // All four request continuously, target acks every cycle
    rst_pulse(0);
    drive(4'b1111);
    m_ack = 1'b1;
    tick();
    for (int r = 0; r < 5; r++) begin
      chk("rotate", 32'(gnt), 32'd1 << (r % 4));
      tick();
      drive(4'b1111);
    end
    drain();

    // Lone initiator 2 back-to-back: one idle cycle between grants
    drive(4'b0100);
    m_ack = 1'b1;
    tick();
    chk("b2b_gnt", 32'(gnt),   32'b0100);
    chk("b2b_bus", 32'(m_bus), 32'(s_bus[2*BW +: BW]));
    tick();
    chk("b2b_idle", 32'(gnt), 32'd0);
    drive(4'b0100);
    tick();
    chk("b2b_regnt", 32'(gnt), 32'b0100);
    drain();

    // Target stalls ack on initiator 3 while 0 waits
    rst_pulse(0);
    drive(4'b1000);
    tick();
    drive(4'b1001);
    repeat (3) begin
      tick();
      chk("hold3", 32'(gnt), 32'b1000);
    end
    m_ack = 1'b1;
    tick();
    chk("to0", 32'(gnt), 32'b0001);

    // Reset mid-transfer with ack low, then restart from pointer 0
    m_ack = 1'b0;
    drive(4'b1001);
    tick();
    rst_pulse(2);
    drive(4'b1111);
    tick();
    chk("rst_ptr", 32'(gnt), 32'b0001);
    drain();

`ifdef ZBUS_ARB_LOCK_EN
    // Initiator 1 locks the target for three transfers
    drive(4'b0010);
    tick();
    s_lck = 4'b0010;
    drive(4'b0111);
    m_ack = 1'b1;
    tick();
    chk("lock1", 32'(gnt), 32'b0010);
    drive(4'b0111);
    tick();
    chk("lock2", 32'(gnt), 32'b0010);
    s_lck = '0;
    drive(4'b0111);
    tick();
    chk("lock3", 32'(gnt), 32'b0100);
    drain();
`endif

    // Randomized traffic against the model
    repeat (1500) begin
      m_ack = 1'($urandom);
`ifdef ZBUS_ARB_LOCK_EN
      s_lck = 4'($urandom);
`endif
      drive(4'($urandom));
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/zbus_arbiter.md
Name: zbus_arbiter

Overview:
- Round-robin arbiter sharing one zbus target (sink) between N zbus initiators (sources).
- Holds a grant for the whole of a transfer, from grant until vld&ack, then re-arbitrates.
- Multiplexes vld/bus toward the target and routes ack back to the granted initiator only.
- Used in benches and RTL wherever several zbus_source-style masters drive one slave.

Parameters:
- N, 2, number of requesting initiators (N >= 2).
- BW, 8, width of the grouped zbus bus signal.
- XZ, 1'bx, fill value driven on m_bus when no grant is active.

Ports:
- z_clk  input  1  system clock, all state updates on rising edge.
- z_rst_n  input  1  reset, asynchronous, active-low.
- s_vld  input  N  per-initiator transfer valid.
- s_bus  input  N*BW  per-initiator bus; initiator i occupies bits [i*BW +: BW].
- s_ack  output  N  per-initiator acknowledge.
- m_vld  output  1  valid toward shared target.
- m_bus  output  BW  bus toward shared target.
- m_ack  input  1  acknowledge from shared target.
- gnt  output  N  one-hot current grant; all-zero when idle.

Behaviour:
- Reset (z_rst_n low, async):
  - state=IDLE, gnt=0, round-robin pointer ptr=0.
  - m_vld=0, m_bus={BW{XZ}}, s_ack=0.
  - Reset asserted mid-transfer aborts the transfer immediately; no ack is delivered.
- zbus rule: a transfer completes on the rising edge where vld&ack=1. Initiators hold vld/bus stable until completion.
- States: IDLE, BUSY.
- IDLE:
  - gnt=0, m_vld=0, m_bus=XZ fill, s_ack=0.
  - If any s_vld is high at the edge, go to BUSY and grant the first requester found searching ptr, ptr+1, ... N-1, 0, ... (wrap-around).
  - Arbitration latency: 1 cycle from s_vld rise to m_vld rise.
- BUSY with grant g (combinational paths):
  - m_vld=s_vld[g], m_bus=s_bus[g].
  - s_ack[g]=m_ack; s_ack of all other initiators is 0.
- Completion (m_vld&m_ack at an edge):
  - ptr <= g+1 mod N.
  - Search s_vld excluding g, starting at g+1 with wrap.
  - If a requester is found, grant it directly (stay BUSY, zero idle cycle); otherwise go to IDLE.
  - Initiator g may re-request; it is served at the next arbitration, after IDLE if it is alone.
- Granted initiator drops s_vld without completion (protocol violation): grant is held, m_vld follows s_vld, and the block waits.
- m_ack while not BUSY is ignored.
- Non-granted s_vld has no effect on outputs; these requests wait.
- Fairness: each continuously requesting initiator is served within N transfers.
- gnt changes only at clock edges or on reset.

Optional Feature:
- Macro ZBUS_ARB_LOCK_EN.
- Defined:
  - Adds input s_lck [N].
  - If s_lck[g]=1 at the completion edge, the grant stays with g, state stays BUSY, and ptr is not advanced. This allows atomic multi-transfer sequences.
  - The lock is released by the first completion with s_lck[g]=0.
- Undefined:
  - The s_lck port does not exist.
  - Every completion re-arbitrates as described in Behaviour.

Test Plan:
- Reset checks:
  - Assert z_rst_n=0 -> gnt=0, m_vld=0, m_bus=all XZ, s_ack=0.
  - Release reset; s_vld[1]=1 -> gnt=4'b0010 and m_vld=1 one cycle later.
- Four initiators (N=4) all request continuously, target acks every cycle -> grants rotate 0,1,2,3,0 with no idle cycle between transfers; each s_ack pulse goes to the granted index only.
- Only initiator 2 requests back-to-back -> grant, complete, one IDLE cycle, grant 2 again; m_bus equals s_bus slice 2 while granted.
- Target delays m_ack 3 cycles while initiator 0 requests during BUSY on 3 -> grant held on 3 for the full 3 cycles, then moves to 0 at completion.
- Reset pulse mid-transfer with m_ack still low -> outputs return to reset values asynchronously; after release, arbitration restarts from ptr=0.
- ZBUS_ARB_LOCK_EN: initiator 1 holds s_lck=1 for 3 transfers while 0 and 2 request -> three consecutive grants to 1, then the grant passes to 2.
